// File: rtl/hazard_forward_unit_pkg.sv
// Shared constants for the hazard/forwarding controller and the execute-stage forward muxes.
package hazard_forward_unit_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_forward_unit_forward_select.sv
// Combinational forward-source select for one execute-stage operand.
module hazard_forward_unit_forward_select
    import hazard_forward_unit_pkg::*;
#(
    parameter int ADDR_W = hazard_forward_unit_pkg::REG_ADDR_W
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] mem_wr,
    input  logic              mem_regwrite,
    input  logic [ADDR_W-1:0] wb_wr,
    input  logic              wb_regwrite,
    output fwd_sel_t          sel
);

    always_comb begin
        sel = FWD_REG;
        // $0 is hard-wired, so a match on it must never redirect the operand.
        if (en && (src != '0)) begin
            if (mem_regwrite && (mem_wr == src)) begin
                sel = FWD_MEM;
            end else if (wb_regwrite && (wb_wr == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control for the 5-stage pipeline.
// Define HAZARD_FORWARD_EN for forwarding + load-use stall; otherwise it is a full interlock.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = hazard_forward_unit_pkg::REG_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic [REG_ADDR_W-1:0] EX_Rs,
    input  logic [REG_ADDR_W-1:0] EX_Rt,
    input  logic                  EX_UsesRt,
    input  logic [REG_ADDR_W-1:0] EX_WriteRegister,
    input  logic                  EX_RegWrite,
    input  logic                  EX_MemRead,
    input  logic                  BranchFlush,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB,
    output logic                  PCWrite,
    output logic                  IFIDWrite,
    output logic                  IFIDFlush,
    output logic                  IDEXFlush,
    output logic [CNT_W-1:0]      StallCount
);
    import hazard_forward_unit_pkg::*;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic [REG_ADDR_W-1:0] mem_wr_q, mem_wr_d;
    logic                  mem_regwrite_q, mem_regwrite_d;
    logic [REG_ADDR_W-1:0] wb_wr_q, wb_wr_d;
    logic                  wb_regwrite_q, wb_regwrite_d;
    logic                  idex_flush_q, idex_flush_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic                  load_use;
    logic                  dep_rs;
    logic                  dep_rt;
    logic                  stall;

    logic [1:0][REG_ADDR_W-1:0] fwd_src;
    logic [1:0]                 fwd_en;
    fwd_sel_t [1:0]             fwd_sel;

    assign fwd_src[0] = EX_Rs;
    assign fwd_src[1] = EX_Rt;
    assign fwd_en[0]  = FWD_ON;
    assign fwd_en[1]  = FWD_ON & EX_UsesRt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            hazard_forward_unit_forward_select #(
                .ADDR_W(REG_ADDR_W)
            ) u_sel (
                .en          (fwd_en[gi]),
                .src         (fwd_src[gi]),
                .mem_wr      (mem_wr_q),
                .mem_regwrite(mem_regwrite_q),
                .wb_wr       (wb_wr_q),
                .wb_regwrite (wb_regwrite_q),
                .sel         (fwd_sel[gi])
            );
        end
    endgenerate

    assign ForwardA   = fwd_sel[0];
    assign ForwardB   = fwd_sel[1];
    assign StallCount = stall_cnt_q;

    always_comb begin
        load_use = EX_MemRead && EX_RegWrite && (EX_WriteRegister != '0) &&
                   ((EX_WriteRegister == ID_Rs) || (EX_WriteRegister == ID_Rt));
        // Interlock mode: hold a dependent instruction until its producer reaches WB.
        dep_rs = (ID_Rs != '0) &&
                 ((EX_RegWrite && (EX_WriteRegister == ID_Rs)) ||
                  (mem_regwrite_q && (mem_wr_q == ID_Rs)));
        dep_rt = (ID_Rt != '0) &&
                 ((EX_RegWrite && (EX_WriteRegister == ID_Rt)) ||
                  (mem_regwrite_q && (mem_wr_q == ID_Rt)));
        stall = FWD_ON ? load_use : (dep_rs || dep_rt);

        // A taken branch squashes the stalled instruction, so it wins over a stall.
        PCWrite   = Rst || BranchFlush || !stall;
        IFIDWrite = Rst || BranchFlush || !stall;
        IFIDFlush = !Rst && BranchFlush;
        IDEXFlush = !Rst && (BranchFlush || stall);
    end

    always_comb begin
        mem_wr_d       = EX_WriteRegister;
        // The cycle after a flush, EX holds a bubble that must not be forwarded.
        mem_regwrite_d = EX_RegWrite && !idex_flush_q;
        wb_wr_d        = mem_wr_q;
        wb_regwrite_d  = mem_regwrite_q;
        idex_flush_d   = IDEXFlush;
        stall_cnt_d    = stall_cnt_q;
        if (!PCWrite && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mem_wr_q       <= '0;
            mem_regwrite_q <= 1'b0;
            wb_wr_q        <= '0;
            wb_regwrite_q  <= 1'b0;
            idex_flush_q   <= 1'b0;
            stall_cnt_q    <= '0;
        end else begin
            mem_wr_q       <= mem_wr_d;
            mem_regwrite_q <= mem_regwrite_d;
            wb_wr_q        <= wb_wr_d;
            wb_regwrite_q  <= wb_regwrite_d;
            idex_flush_q   <= idex_flush_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

endmodule
